// File: rtl/result_check.sv
// result_check: consumer of the check FIFO and the result FIFO.
// Each test vector pops one expected entry {dont_care, expected, vec_addr} and one captured
// DUT word. It compares them under the programmable bitmask and the per-vector don't-care
// mask, counts passes and fails, and writes a 6-word failure record through an Avalon-MM
// write master.
//
// Ports:
//   clock_i, reset_n_i         clock, asynchronous active-low reset
//   clear_i                    one-cycle pulse: counters, record pointer, overflow, bitmask
//   cfifo_*                    check FIFO read side (non-showahead)
//   rfifo_*                    result FIFO read side (non-showahead)
//   sc_cmd_i, sc_data_i        STIM=>CHECK command channel (set bitmask)
//   sc_ready_o, done_o         idle with both FIFOs empty
//   mem_*                      Avalon-MM write master to result memory
//   pass_count_o, fail_count_o saturating counters
//   overflow_o                 sticky: a record was dropped because result memory was full
//
// Build option: define RESULT_CHECK_LOG_ALL_EN to write a record for every vector
// (passing vectors carry pass_flag=1 and mismatch=0).
module result_check #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned STF_WIDTH  = 24,
    parameter int unsigned RTF_WIDTH  = 24,
    parameter int unsigned CHF_WIDTH  = RTF_WIDTH + STF_WIDTH + ADDR_WIDTH,
    parameter int unsigned SCC_WIDTH  = 5,
    parameter int unsigned SCD_WIDTH  = 24,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE  = 20'h80000,
    parameter logic [ADDR_WIDTH-1:0] RES_LIMIT = 20'hFFFFF,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    clear_i,
    input  logic [CHF_WIDTH-1:0]    cfifo_data_i,
    output logic                    cfifo_rdreq_o,
    input  logic                    cfifo_rdempty_i,
    input  logic [RTF_WIDTH-1:0]    rfifo_data_i,
    output logic                    rfifo_rdreq_o,
    input  logic                    rfifo_rdempty_i,
    input  logic [SCC_WIDTH-1:0]    sc_cmd_i,
    input  logic [SCD_WIDTH-1:0]    sc_data_i,
    output logic                    sc_ready_o,
    output logic [ADDR_WIDTH-1:0]   mem_address_o,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable_o,
    output logic                    mem_write_o,
    output logic [DATA_WIDTH-1:0]   mem_writedata_o,
    input  logic                    mem_waitrequest_i,
    output logic [CNT_WIDTH-1:0]    pass_count_o,
    output logic [CNT_WIDTH-1:0]    fail_count_o,
    output logic                    overflow_o,
    output logic                    done_o
);

`ifdef RESULT_CHECK_LOG_ALL_EN
    localparam bit LogAll = 1'b1;
`else
    localparam bit LogAll = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StFetch, StCompare, StWrite} state_e;

    localparam logic [SCC_WIDTH-1:0] CmdSetBitmask = SCC_WIDTH'(1);
    localparam logic [2:0]           LastWord      = 3'd5;
    localparam logic [CNT_WIDTH-1:0] CntMax        = '1;

    state_e                state_q, state_d;
    logic [2:0]            word_q, word_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  clr_ptr_q, clr_ptr_d;
    logic [ADDR_WIDTH-1:0] vec_addr_q, vec_addr_d;
    logic [RTF_WIDTH-1:0]  actual_q, actual_d;
    logic [RTF_WIDTH-1:0]  mismatch_q, mismatch_d;
    logic                  pass_flag_q, pass_flag_d;
    logic [RTF_WIDTH-1:0]  bitmask_q, bitmask_d;
    logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
    logic                  overflow_q, overflow_d;

    // Check-FIFO entry fields, MSB first: {dont_care, expected, vec_addr}.
    logic [RTF_WIDTH-1:0]  chk_dont_care;
    logic [STF_WIDTH-1:0]  chk_expected;
    logic [ADDR_WIDTH-1:0] chk_vec_addr;
    logic [RTF_WIDTH-1:0]  cmp_mismatch;
    logic                  cmp_pass;
    logic                  rec_room;

    assign chk_dont_care = cfifo_data_i[CHF_WIDTH-1 -: RTF_WIDTH];
    assign chk_expected  = cfifo_data_i[ADDR_WIDTH +: STF_WIDTH];
    assign chk_vec_addr  = cfifo_data_i[ADDR_WIDTH-1:0];

    assign cmp_mismatch = (chk_expected ^ rfifo_data_i) & bitmask_q & ~chk_dont_care;
    assign cmp_pass     = (cmp_mismatch == '0);
    // One extra bit so ptr+5 cannot wrap past the top of the address space.
    assign rec_room     = ({1'b0, ptr_q} + (ADDR_WIDTH + 1)'(5)) <= {1'b0, RES_LIMIT};

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        ptr_d       = ptr_q;
        clr_ptr_d   = clr_ptr_q;
        vec_addr_d  = vec_addr_q;
        actual_d    = actual_q;
        mismatch_d  = mismatch_q;
        pass_flag_d = pass_flag_q;
        bitmask_d   = bitmask_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (!cfifo_rdempty_i && !rfifo_rdempty_i) state_d = StFetch;
            end
            StFetch: begin
                state_d = StCompare;
            end
            StCompare: begin
                vec_addr_d  = chk_vec_addr;
                actual_d    = rfifo_data_i;
                mismatch_d  = cmp_mismatch;
                pass_flag_d = LogAll & cmp_pass;
                if (cmp_pass) begin
                    if (pass_cnt_q != CntMax) pass_cnt_d = pass_cnt_q + 1'b1;
                end else begin
                    if (fail_cnt_q != CntMax) fail_cnt_d = fail_cnt_q + 1'b1;
                end
                state_d = StIdle;
                if (LogAll || !cmp_pass) begin
                    if (rec_room) state_d    = StWrite;
                    else          overflow_d = 1'b1;
                end
            end
            StWrite: begin
                if (!mem_waitrequest_i) begin
                    if (word_q == LastWord) begin
                        word_d    = '0;
                        ptr_d     = clr_ptr_q ? RES_BASE : ptr_q + ADDR_WIDTH'(6);
                        clr_ptr_d = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear_i) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            overflow_d = 1'b0;
            bitmask_d  = '1;
            // A record in flight completes at its old addresses; rewind afterwards.
            if (state_q == StWrite && state_d == StWrite) begin
                clr_ptr_d = 1'b1;
            end else begin
                ptr_d     = RES_BASE;
                clr_ptr_d = 1'b0;
            end
        end

        // The sender does not handshake, so a set is taken on any cycle.
        if (sc_cmd_i == CmdSetBitmask) bitmask_d = RTF_WIDTH'(sc_data_i);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            word_q      <= '0;
            ptr_q       <= RES_BASE;
            clr_ptr_q   <= 1'b0;
            vec_addr_q  <= '0;
            actual_q    <= '0;
            mismatch_q  <= '0;
            pass_flag_q <= 1'b0;
            bitmask_q   <= '1;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            ptr_q       <= ptr_d;
            clr_ptr_q   <= clr_ptr_d;
            vec_addr_q  <= vec_addr_d;
            actual_q    <= actual_d;
            mismatch_q  <= mismatch_d;
            pass_flag_q <= pass_flag_d;
            bitmask_q   <= bitmask_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Record word layout; address and data derive only from registers, so they stay
    // stable while the slave stalls.
    always_comb begin
        mem_writedata_o = '0;
        if (state_q == StWrite) begin
            case (word_q)
                3'd0:    mem_writedata_o = vec_addr_q[15:0];
                3'd1:    mem_writedata_o = {pass_flag_q, 11'b0, vec_addr_q[19:16]};
                3'd2:    mem_writedata_o = actual_q[15:0];
                3'd3:    mem_writedata_o = {8'b0, actual_q[23:16]};
                3'd4:    mem_writedata_o = mismatch_q[15:0];
                3'd5:    mem_writedata_o = {8'b0, mismatch_q[23:16]};
                default: mem_writedata_o = '0;
            endcase
        end
    end

    assign mem_address_o    = ptr_q + ADDR_WIDTH'(word_q);
    assign mem_byteenable_o = '1;
    assign mem_write_o      = (state_q == StWrite);
    assign cfifo_rdreq_o    = (state_q == StFetch);
    assign rfifo_rdreq_o    = (state_q == StFetch);
    assign sc_ready_o       = (state_q == StIdle) && cfifo_rdempty_i && rfifo_rdempty_i;
    assign done_o           = (state_q == StIdle) && cfifo_rdempty_i && rfifo_rdempty_i;
    assign pass_count_o     = pass_cnt_q;
    assign fail_count_o     = fail_cnt_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_result_check.sv
// Self-checking bench for result_check: FIFO and memory-slave models, a vector-level
// reference model with an expected-write queue, and literal expectations for key cases.
module tb_result_check;

`ifdef RESULT_CHECK_LOG_ALL_EN
    localparam bit LOG_ALL = 1'b1;
`else
    localparam bit LOG_ALL = 1'b0;
`endif
    localparam int BASE  = 'h80000;
    localparam int LIMIT = 'h80007;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [67:0] cfifo_data = '0;
    logic        cfifo_rdreq;
    logic        cfifo_rdempty = 1'b1;
    logic [23:0] rfifo_data = '0;
    logic        rfifo_rdreq;
    logic        rfifo_rdempty = 1'b1;
    logic [4:0]  sc_cmd = '0;
    logic [23:0] sc_data = '0;
    logic        sc_ready;
    logic [19:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic [15:0] pass_count, fail_count;
    logic        overflow, done;

    result_check #(.RES_LIMIT(20'h80007)) dut (
        .clock_i(clock), .reset_n_i(reset_n), .clear_i(clear),
        .cfifo_data_i(cfifo_data), .cfifo_rdreq_o(cfifo_rdreq), .cfifo_rdempty_i(cfifo_rdempty),
        .rfifo_data_i(rfifo_data), .rfifo_rdreq_o(rfifo_rdreq), .rfifo_rdempty_i(rfifo_rdempty),
        .sc_cmd_i(sc_cmd), .sc_data_i(sc_data), .sc_ready_o(sc_ready),
        .mem_address_o(mem_address), .mem_byteenable_o(mem_byteenable),
        .mem_write_o(mem_write), .mem_writedata_o(mem_writedata),
        .mem_waitrequest_i(mem_waitrequest),
        .pass_count_o(pass_count), .fail_count_o(fail_count),
        .overflow_o(overflow), .done_o(done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO models (non-showahead) ----------------
    logic [67:0] cq[$];
    logic [23:0] rq[$];
    logic [67:0] cfd;
    logic [23:0] rfd;

    always @(posedge clock) begin
        if (cfifo_rdreq && cq.size() > 0) begin
            cfd = cq.pop_front();
            cfifo_data    <= cfd;
            cfifo_rdempty <= (cq.size() == 0);
        end
        if (rfifo_rdreq && rq.size() > 0) begin
            rfd = rq.pop_front();
            rfifo_data    <= rfd;
            rfifo_rdempty <= (rq.size() == 0);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;
    wr_t         exp_q[$];
    logic [23:0] m_mask = 24'hFFFFFF;
    int          m_pass = 0;
    int          m_fail = 0;
    bit          m_ovf = 1'b0;
    int          m_ptr = BASE;
    logic [23:0] last_mm;

    task automatic push_vec(input logic [23:0] dc, input logic [23:0] ex,
                            input logic [23:0] act, input logic [19:0] va);
        logic [23:0] mm;
        logic [15:0] w[6];
        bit          ok;
        mm = (ex ^ act) & m_mask & ~dc;
        last_mm = mm;
        ok = (mm == 24'h0);
        if (ok) m_pass++;
        else    m_fail++;
        if (LOG_ALL || !ok) begin
            if (m_ptr + 5 <= LIMIT) begin
                w[0] = va[15:0];
                w[1] = {ok, 11'b0, va[19:16]};
                w[2] = act[15:0];
                w[3] = {8'h00, act[23:16]};
                w[4] = mm[15:0];
                w[5] = {8'h00, mm[23:16]};
                for (int i = 0; i < 6; i++) exp_q.push_back('{addr: m_ptr + i, data: w[i]});
                m_ptr += 6;
            end else begin
                m_ovf = 1'b1;
            end
        end
        cq.push_back({dc, ex, va});
        rq.push_back(act);
        cfifo_rdempty = 1'b0;
        rfifo_rdempty = 1'b0;
    endtask

    // ---------------- memory slave + write compare ----------------
    int          stall_left = 0;
    int          stall_addr = 0;
    bit          hold_prev = 1'b0;
    logic [19:0] prev_addr;
    logic [15:0] prev_data;
    logic [15:0] mem_seen[int];
    int          wr_cnt[int];

    always @(negedge clock) begin
        if (reset_n) begin
            if (hold_prev) begin
                chk("hold_addr", 32'(mem_address), 32'(prev_addr));
                chk("hold_data", 32'(mem_writedata), 32'(prev_data));
            end
            if (stall_left > 0 && mem_write && int'(mem_address) == stall_addr) begin
                mem_waitrequest = 1'b1;
                stall_left--;
            end else begin
                mem_waitrequest = 1'b0;
            end
            hold_prev = mem_write && mem_waitrequest;
            prev_addr = mem_address;
            prev_data = mem_writedata;
            if (mem_write && !mem_waitrequest) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                             mem_address, mem_writedata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_address), 32'(e.addr));
                    chk("wr_data", 32'(mem_writedata), 32'(e.data));
                end
                mem_seen[int'(mem_address)] = mem_writedata;
                if (wr_cnt.exists(int'(mem_address))) wr_cnt[int'(mem_address)]++;
                else                                  wr_cnt[int'(mem_address)] = 1;
            end
            if ((cfifo_rdreq && cfifo_rdempty) || (rfifo_rdreq && rfifo_rdempty)) begin
                total++;
                bad++;
                $display("FAIL pop_empty: rdreq %0b/%0b while empty %0b/%0b, expected no pop",
                         cfifo_rdreq, rfifo_rdreq, cfifo_rdempty, rfifo_rdempty);
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!done && cyc < 300);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_pass"}, 32'(pass_count), 32'(m_pass));
        chk({name, "_fail"}, 32'(fail_count), 32'(m_fail));
        chk({name, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        m_pass = 0;
        m_fail = 0;
        m_ovf  = 1'b0;
        m_ptr  = BASE;
        m_mask = 24'hFFFFFF;
        mem_seen.delete();
        wr_cnt.delete();
    endtask

    task automatic set_mask(input logic [23:0] v);
        sc_cmd  = 5'b00001;
        sc_data = v;
        @(negedge clock);
        sc_cmd  = 5'b00000;
        m_mask  = v;
    endtask

    int          cyc;
    logic [15:0] t2_words[6];

    initial begin
        t2_words[0] = 16'h2345; t2_words[1] = 16'h0001; t2_words[2] = 16'h0011;
        t2_words[3] = 16'h0000; t2_words[4] = 16'h0010; t2_words[5] = 16'h0000;

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_addr", 32'(mem_address), 32'h80000);
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_wdata", 32'(mem_writedata), 32'd0);
        chk("rst_rdreq", 32'({cfifo_rdreq, rfifo_rdreq}), 32'd0);
        chk("rst_cnt", 32'({pass_count, fail_count}), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd1);
        chk("rst_be", 32'(mem_byteenable), 32'h3);
        reset_n = 1'b1;
        @(negedge clock);

        // Exact match passes.
        push_vec(24'h0, 24'hA5A5A5, 24'hA5A5A5, 20'h00001);
        wait_done("t1", cyc);
        chk("t1_pass_lit", 32'(pass_count), 32'd1);
`ifdef RESULT_CHECK_LOG_ALL_EN
        chk("t1_w1_lit", 32'(mem_seen[BASE + 1]), 32'h8000);
        chk("t1_w4_lit", 32'(mem_seen[BASE + 4]), 32'h0000);
        chk("t1_w5_lit", 32'(mem_seen[BASE + 5]), 32'h0000);
        chk("t1_w2_lit", 32'(mem_seen[BASE + 2]), 32'hA5A5);
`else
        chk("t1_nowrite_lit", 32'(wr_cnt.size()), 32'd0);
`endif

        // Failing vector with a don't-care bit.
        do_clear();
        push_vec(24'h000001, 24'h000000, 24'h000011, 20'h12345);
        chk("t2_mm_model", 32'(last_mm), 32'h000010);
        wait_done("t2", cyc);
        chk("t2_fail_lit", 32'(fail_count), 32'd1);
        for (int i = 0; i < 6; i++) chk("t2_word_lit", 32'(mem_seen[BASE + i]), 32'(t2_words[i]));

        // Narrowed bitmask hides a bit-20 difference.
        set_mask(24'h00FFFF);
        push_vec(24'h0, 24'h000000, 24'h100000, 20'h00002);
        wait_done("t3", cyc);
        chk("t3_pass_lit", 32'(pass_count), 32'd1);

        // Stalled slave on w2.
        do_clear();
        stall_addr = BASE + 2;
        stall_left = 3;
        push_vec(24'h0, 24'h0F0F0F, 24'h0F0F00, 20'hABCDE);
        wait_done("t4", cyc);
        for (int i = 0; i < 6; i++) chk("t4_once_lit", 32'(wr_cnt[BASE + i]), 32'd1);
        chk("t4_ptr_lit", 32'(mem_address), 32'h80006);
        chk("t4_stall_used", 32'(stall_left), 32'd0);

        // Second record does not fit below the limit.
        push_vec(24'h0, 24'h000001, 24'h000000, 20'h00003);
        wait_done("t5", cyc);
        chk("t5_ovf_lit", 32'(overflow), 32'd1);
        chk("t5_fail_lit", 32'(fail_count), 32'd2);
        do_clear();
        chk("clr_cnt_lit", 32'({pass_count, fail_count}), 32'd0);
        chk("clr_ovf_lit", 32'(overflow), 32'd0);
        chk("clr_ptr_lit", 32'(mem_address), 32'h80000);

        // Back-to-back passing vectors.
        push_vec(24'h0, 24'h111111, 24'h111111, 20'h00010);
        push_vec(24'hFFFFFF, 24'h123456, 24'h654321, 20'h00011);
        push_vec(24'h0000FF, 24'h0000AA, 24'h000055, 20'h00012);
        wait_done("t6", cyc);
`ifndef RESULT_CHECK_LOG_ALL_EN
        chk("t6_cycles_lit", 32'(cyc), 32'd9);
`endif

        // Mixed fail / overflow.
        do_clear();
        push_vec(24'h0, 24'hFFFFFF, 24'h000000, 20'hFEDCB);
        push_vec(24'hF0F0F0, 24'h000000, 24'h0F0F0F, 20'h00020);
        push_vec(24'h0, 24'h555555, 24'h555555, 20'h00021);
        wait_done("t7", cyc);
        chk("t7_w5_lit", 32'(mem_seen[BASE + 5]), 32'h00FF);
        chk("t7_ovf_lit", 32'(overflow), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
